// File: rtl/eth_clk_pkg.sv
// Shared speed encodings, default divisors and the speed-request decoder
// for the Ethernet transmit clock generator.
package eth_clk_pkg;

    typedef logic [1:0] speed_t;

    localparam speed_t SPEED_10   = 2'b00;
    localparam speed_t SPEED_100  = 2'b01;
    localparam speed_t SPEED_1000 = 2'b10;

    localparam int unsigned DIV_10_DEFAULT  = 50;
    localparam int unsigned DIV_100_DEFAULT = 5;
    localparam int unsigned CNT_W_DEFAULT   = 13;

    // The reserved code 11 runs at 10M.
    function automatic speed_t decode_speed(input logic [1:0] s);
        return (s == 2'b11) ? SPEED_10 : speed_t'(s);
    endfunction

endpackage

// File: rtl/eth_clk_lock_mon.sv
// Lock monitor: counts completed periods since the last applied speed change
// and reports lock after two of them.
module eth_clk_lock_mon (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic locked
);

    localparam logic [1:0] LOCK_CNT = 2'd2;

    logic [1:0] period_cnt;
    logic [1:0] period_cnt_nxt;

    // Saturates at LOCK_CNT so locked stays high while the speed is stable.
    always_comb begin
        period_cnt_nxt = period_cnt;
        if (clear) begin
            period_cnt_nxt = 2'd0;
        end else if (tick && (period_cnt != LOCK_CNT)) begin
            period_cnt_nxt = period_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_cnt <= 2'd0;
            locked     <= 1'b0;
        end else begin
            period_cnt <= period_cnt_nxt;
            locked     <= (period_cnt_nxt == LOCK_CNT);
        end
    end

endmodule

// File: rtl/eth_tx_clk_gen.sv
// Multi-speed (10/100/1000) Ethernet transmit clock generator from rx_clk125.
// Optional lock monitor enabled by macro ETH_TX_CLK_GEN_LOCK_EN.
module eth_tx_clk_gen
    import eth_clk_pkg::*;
#(
    parameter int unsigned DIV_10  = DIV_10_DEFAULT,
    parameter int unsigned DIV_100 = DIV_100_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic       rx_clk125,
    input  logic       reset_n,
    input  logic [1:0] speed,
    output logic       tx_clk,
    output logic       tx_clk90,
    output logic       tx_ce,
    output logic       gig_mode,
    output logic [1:0] speed_cur,
    output logic       locked
);

    if ((DIV_10 < 4) || (DIV_100 < 4)) begin : g_div_too_small
        $error("eth_tx_clk_gen: DIV_10 and DIV_100 must be >= 4");
    end
    if ((((DIV_10 - 1) >> CNT_W) != 0) || (((DIV_100 - 1) >> CNT_W) != 0)) begin : g_cnt_too_narrow
        $error("eth_tx_clk_gen: CNT_W too small for divisor");
    end

    localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(DIV_10 - 1);
    localparam logic [CNT_W-1:0] HALF_10  = CNT_W'(DIV_10 / 2);
    localparam logic [CNT_W-1:0] QTR_10   = CNT_W'(DIV_10 / 4);
    localparam logic [CNT_W-1:0] QEND_10  = CNT_W'(DIV_10 / 4 + DIV_10 / 2);
    localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(DIV_100 - 1);
    localparam logic [CNT_W-1:0] HALF_100 = CNT_W'(DIV_100 / 2);
    localparam logic [CNT_W-1:0] QTR_100  = CNT_W'(DIV_100 / 4);
    localparam logic [CNT_W-1:0] QEND_100 = CNT_W'(DIV_100 / 4 + DIV_100 / 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] qtr;
    logic [CNT_W-1:0] qend;
    speed_t           req;
    logic             is_gig;
    logic             at_last;
    logic             apply;

    // Period-boundary thresholds for the speed currently in effect.
    always_comb begin
        last = LAST_10;
        half = HALF_10;
        qtr  = QTR_10;
        qend = QEND_10;
        if (speed_cur == SPEED_100) begin
            last = LAST_100;
            half = HALF_100;
            qtr  = QTR_100;
            qend = QEND_100;
        end
    end

    assign req     = decode_speed(speed);
    assign is_gig  = (speed_cur == SPEED_1000);
    assign at_last = (cnt == last);
    // Speed changes only on a period boundary, or immediately from gig mode.
    assign apply   = (req != speed_cur) && (is_gig || at_last);

    always_ff @(posedge rx_clk125) begin
        if (!reset_n) begin
            cnt       <= '0;
            speed_cur <= SPEED_10;
            tx_clk    <= 1'b0;
            tx_clk90  <= 1'b0;
            tx_ce     <= 1'b0;
            gig_mode  <= 1'b0;
        end else begin
            if (apply) begin
                speed_cur <= req;
            end
            if (is_gig || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            gig_mode <= is_gig;
            tx_clk   <= !is_gig && (cnt < half);
            tx_clk90 <= !is_gig && (cnt >= qtr) && (cnt < qend);
            tx_ce    <= is_gig || (cnt == '0);
        end
    end

`ifdef ETH_TX_CLK_GEN_LOCK_EN
    eth_clk_lock_mon u_lock_mon (
        .clk     (rx_clk125),
        .reset_n (reset_n),
        .clear   (apply),
        .tick    (is_gig || at_last),
        .locked  (locked)
    );
`else
    always_ff @(posedge rx_clk125) begin
        if (!reset_n) begin
            locked <= 1'b0;
        end else begin
            locked <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_clk_gen.sv
// Scoreboard bench for eth_tx_clk_gen: a period-position reference model
// queues expected outputs per edge, a monitor pops and compares them.
module tb_eth_tx_clk_gen;

    localparam int D10  = 50;
    localparam int D100 = 5;

    typedef struct packed {
        logic       tx_clk;
        logic       tx_clk90;
        logic       tx_ce;
        logic       gig;
        logic [1:0] spd;
        logic       locked;
        logic       rst;
    } exp_t;

    logic       rx_clk125;
    logic       reset_n;
    logic [1:0] speed;
    logic       tx_clk;
    logic       tx_clk90;
    logic       tx_ce;
    logic       gig_mode;
    logic [1:0] speed_cur;
    logic       locked;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    eth_tx_clk_gen dut (
        .rx_clk125 (rx_clk125),
        .reset_n   (reset_n),
        .speed     (speed),
        .tx_clk    (tx_clk),
        .tx_clk90  (tx_clk90),
        .tx_ce     (tx_ce),
        .gig_mode  (gig_mode),
        .speed_cur (speed_cur),
        .locked    (locked)
    );

    initial begin
        rx_clk125 = 1'b0;
        forever #5 rx_clk125 = ~rx_clk125;
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: position within the current period and the speed in
    // effect, advanced once per rx_clk125 edge from the rules of operation.
    initial begin : model
        int   pos;
        int   spd;
        int   periods;
        int   d;
        int   req;
        bit   gig;
        bit   boundary;
        bit   changed;
        exp_t e;
        pos = 0; spd = 0; periods = 0;
        forever begin
            @(posedge rx_clk125);
            e = '0;
            if (!reset_n) begin
                pos = 0; spd = 0; periods = 0;
                e.rst = 1'b1;
            end else begin
                d   = (spd == 1) ? D100 : D10;
                gig = (spd == 2);
                e.tx_clk   = !gig && (pos < d / 2);
                e.tx_clk90 = !gig && (pos >= d / 4) && (pos < d / 4 + d / 2);
                e.tx_ce    = gig || (pos == 0);
                e.gig      = gig;
                req        = (speed == 2'b11) ? 0 : int'(speed);
                boundary   = gig || (pos == d - 1);
                changed    = 1'b0;
                if (boundary) begin
                    if (req != spd) begin
                        spd     = req;
                        changed = 1'b1;
                    end
                    pos = 0;
                end else begin
                    pos++;
                end
                if (changed) periods = 0;
                else if (boundary && periods < 2) periods++;
`ifdef ETH_TX_CLK_GEN_LOCK_EN
                e.locked = (periods == 2);
`else
                e.locked = 1'b1;
`endif
            end
            e.spd = 2'(spd);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the queued expectation, and
    // check that no tx_clk phase outside a reset is shorter than 2 cycles.
    initial begin : monitor
        exp_t e;
        logic prev_clk;
        int   run_len;
        bit   tainted;
        prev_clk = 1'b0; run_len = 0; tainted = 1'b1;
        forever begin
            @(negedge rx_clk125);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tx_clk",    {1'b0, tx_clk},   {1'b0, e.tx_clk});
                chk("tx_clk90",  {1'b0, tx_clk90}, {1'b0, e.tx_clk90});
                chk("tx_ce",     {1'b0, tx_ce},    {1'b0, e.tx_ce});
                chk("gig_mode",  {1'b0, gig_mode}, {1'b0, e.gig});
                chk("speed_cur", speed_cur,        e.spd);
                chk("locked",    {1'b0, locked},   {1'b0, e.locked});
                if (e.rst) tainted = 1'b1;
                if (tx_clk !== prev_clk) begin
                    if (!tainted) chk("min_phase", {1'b0, run_len >= 2}, 2'd1);
                    run_len  = 1;
                    tainted  = e.rst;
                    prev_clk = tx_clk;
                end else begin
                    run_len++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge rx_clk125);
        #2;
    endtask

    initial begin : driver
        reset_n = 1'b0;
        speed   = 2'b00;
        step(3);
        reset_n = 1'b1;
        // 10M boundary, then steady 100M
        speed = 2'b01;
        step(120);
        // Steady 10M for over 10 periods
        reset_n = 1'b0; speed = 2'b00;
        step(2);
        reset_n = 1'b1;
        step(520);
        // Request 100M part-way into a 10M period
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(20);
        speed = 2'b01;
        step(60);
        // Gig mode and back to 100M
        speed = 2'b10;
        step(30);
        speed = 2'b01;
        step(30);
        // Reserved code runs as 10M
        speed = 2'b11;
        step(160);
        // Reset a few cycles into a 100M period
        speed = 2'b01;
        step(80);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(20);
        // Random speed requests, mid-period toggles and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 599) != 0);
            step(1);
        end
        reset_n = 1'b1;
        step(10);
        @(negedge rx_clk125);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
